// File: rtl/button_event_pkg.sv
// Shared types and constants for the button_event block: FSM state encodings
// and the press counter width.
package button_event_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_e;

  localparam int PRESS_CNT_W = 8;

  // The press counter is modulo 2^PRESS_CNT_W, so 255 wraps to 0.
  function automatic logic [PRESS_CNT_W-1:0] press_cnt_inc(input logic [PRESS_CNT_W-1:0] v);
    return v + PRESS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/button_event_edge_detect.sv
// Reusable edge detector: registers a clk-synchronous level and flags its
// rising and falling edges combinationally against the registered copy.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o,
  output logic d_q_o
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;
  assign d_q_o  = d_q;

endmodule

// File: rtl/button_event.sv
// Converts a debounced button level into press/release/long-press/repeat pulses
// and a wrapping press counter. Auto-repeat is enabled by BUTTON_EVENT_AUTO_REPEAT_EN.
module button_event
  import button_event_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int LONG_CYCLES   = 50000,
  parameter int REPEAT_CYCLES = 10000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_i,
  output logic                   press_o,
  output logic                   release_o,
  output logic                   long_press_o,
  output logic                   repeat_o,
  output logic                   held_o,
  output logic [PRESS_CNT_W-1:0] press_count_o
);

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

  logic rise, fall, in_q;

  edge_detect u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (in_i),
    .rise_o (rise),
    .fall_o (fall),
    .d_q_o  (in_q)
  );

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PRESS_CNT_W-1:0] press_count_q, press_count_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   long_q, long_d;
  logic                   repeat_q, repeat_d;
  logic                   held_q, held_d;
  logic                   tc_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      press_count_q <= '0;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      long_q        <= 1'b0;
      repeat_q      <= 1'b0;
      held_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      press_count_q <= press_count_d;
      press_q       <= press_d;
      release_q     <= release_d;
      long_q        <= long_d;
      repeat_q      <= repeat_d;
      held_q        <= held_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    press_count_d = press_count_q;
    press_d       = 1'b0;
    release_d     = 1'b0;
    long_d        = 1'b0;
    repeat_d      = 1'b0;
    tc_hit        = (cnt_q == ((state_q == PRESS) ? LONG_TC : REPEAT_TC));

    // Edges take precedence, so a release landing on a terminal count wins.
    if (rise) begin
      press_d       = 1'b1;
      state_d       = PRESS;
      cnt_d         = '0;
      press_count_d = press_cnt_inc(press_count_q);
    end else if (fall && state_q != IDLE) begin
      release_d = 1'b1;
      state_d   = IDLE;
      cnt_d     = '0;
    end else if (in_i && in_q) begin
      case (state_q)
        PRESS: begin
          if (tc_hit) begin
            long_d  = 1'b1;
            state_d = LONG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LONG: begin
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
          if (tc_hit) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`else
          cnt_d = cnt_q;
`endif
        end
        default: ;
      endcase
    end

    held_d = (state_d != IDLE);
  end

  assign press_o       = press_q;
  assign release_o     = release_q;
  assign long_press_o  = long_q;
  assign repeat_o      = repeat_q;
  assign held_o        = held_q;
  assign press_count_o = press_count_q;

endmodule

// File: tb/tb_button_event.sv
// Table-driven bench for button_event with small counters (LONG=8, REPEAT=4),
// plus hand-written sequences for press-count wrap and async reset in LONG.
module tb_button_event;

`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_r;
  logic       press, rel, lp, rp, held;
  logic [7:0] pcnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_event #(
    .CNT_W         (4),
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_i          (in_r),
    .press_o       (press),
    .release_o     (rel),
    .long_press_o  (lp),
    .repeat_o      (rp),
    .held_o        (held),
    .press_count_o (pcnt)
  );

  typedef struct {
    bit       in;
    bit       press;
    bit       rel;
    bit       lp;
    bit       rp;
    bit       held;
    bit [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit i, bit p, bit r, bit l, bit rpt, bit h, bit [7:0] c);
    vec_t v;
    v.in = i; v.press = p; v.rel = r; v.lp = l; v.rp = rpt; v.held = h; v.cnt = c;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s idx=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(string tag, int idx, bit p, bit r, bit l, bit rpt, bit h, bit [7:0] c);
    check({tag, ".press"}, idx, 32'(press), 32'(p));
    check({tag, ".release"}, idx, 32'(rel), 32'(r));
    check({tag, ".long"}, idx, 32'(lp), 32'(l));
    check({tag, ".repeat"}, idx, 32'(rp), 32'(rpt));
    check({tag, ".held"}, idx, 32'(held), 32'(h));
    check({tag, ".count"}, idx, 32'(pcnt), 32'(c));
  endtask

  task automatic step(bit v);
    in_r = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_r  = 1'b0;

    // Idle after reset
    for (int k = 0; k < 20; k++) add(0, 0, 0, 0, 0, 0, 8'd0);
    // Short press, 3 cycles
    add(1, 1, 0, 0, 0, 1, 8'd1);
    add(1, 0, 0, 0, 0, 1, 8'd1);
    add(1, 0, 0, 0, 0, 1, 8'd1);
    add(0, 0, 1, 0, 0, 0, 8'd1);
    add(0, 0, 0, 0, 0, 0, 8'd1);
    add(0, 0, 0, 0, 0, 0, 8'd1);
    // Long hold, 20 cycles; release lands on a repeat terminal count
    for (int k = 0; k < 20; k++)
      add(1, k == 0, 0, k == 8, AUTO && (k == 12 || k == 16), 1, 8'd2);
    add(0, 0, 1, 0, 0, 0, 8'd2);
    add(0, 0, 0, 0, 0, 0, 8'd2);
    // Release on the long-press terminal edge
    for (int k = 0; k < 8; k++) add(1, k == 0, 0, 0, 0, 1, 8'd3);
    add(0, 0, 1, 0, 0, 0, 8'd3);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0, 8'd3);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].in);
      $display("vec %0d in=%0b press=%0b rel=%0b long=%0b rep=%0b held=%0b cnt=%0d",
               i, vecs[i].in, press, rel, lp, rp, held, pcnt);
      check_all("vec", i, vecs[i].press, vecs[i].rel, vecs[i].lp, vecs[i].rp,
                vecs[i].held, vecs[i].cnt);
    end

    // Press counter wrap across 257 presses from reset
    rst_n = 1'b0;
    #1;
    check("wrap.reset_count", 0, 32'(pcnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 257; i++) begin
      bit [7:0] exp_cnt;
      exp_cnt = 8'(i);
      step(1'b1);
      check("wrap.press", i, 32'(press), 32'd1);
      check("wrap.count", i, 32'(pcnt), 32'(exp_cnt));
      step(1'b0);
      check("wrap.release", i, 32'(rel), 32'd1);
    end
    $display("wrap done count=%0d", pcnt);
    check("wrap.final", 257, 32'(pcnt), 32'd1);

    // Async reset while in LONG, button still held at deassert
    for (int k = 0; k < 10; k++) step(1'b1);
    check("rst6.held_before", 0, 32'(held), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("rst6.during", 0, 0, 0, 0, 0, 0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1);
    $display("rst6 first edge press=%0b count=%0d held=%0b", press, pcnt, held);
    check_all("rst6.first", 1, 1, 0, 0, 0, 1, 8'd1);
    step(1'b1);
    check_all("rst6.second", 2, 0, 0, 0, 0, 1, 8'd1);
    step(1'b0);
    check_all("rst6.release", 3, 0, 1, 0, 0, 0, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
